// File: rtl/flash_responder_if.sv
// Avalon-MM read channel between a flash initiator and the flash responder.
interface flash_responder_if #(
  parameter int unsigned ADDR_W = 23
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_burstcount;
  logic              flash_mem_waitrequest;
  logic              flash_mem_readdatavalid;
  logic [31:0]       flash_mem_readdata;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    output flash_mem_burstcount,
    input  flash_mem_waitrequest,
    input  flash_mem_readdatavalid,
    input  flash_mem_readdata
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    input  flash_mem_burstcount,
    output flash_mem_waitrequest,
    output flash_mem_readdatavalid,
    output flash_mem_readdata
  );
endinterface

// File: rtl/flash_responder.sv
// Stand-in for the flash controller: single-word Avalon-MM reads from a
// preloadable word array with programmable wait states and read latency.
module flash_responder #(
  parameter int unsigned ADDR_W       = 23,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  flash_responder_if.slave         bus,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic                     addr_err,
  output logic [15:0]              reads_served
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned WCNT_W = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned LCNT_W = (READ_LATENCY > 3) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT, GRANT, LAT, VALID} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              capture;
  logic [ADDR_W-1:0] cap_addr;
  logic [3:0]        cap_be;
  logic              cap_burst;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_word;
  logic [31:0]       rd_masked;
  logic              legal;

  // Preload port; the array is never cleared by reset.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign rd_word = mem[cap_addr[IDX_W-1:0]];
  assign legal   = ({1'b0, cap_addr} < DEPTH_L) && cap_burst;

  // Zero every byte lane whose enable is low.
  always_comb begin
    rd_masked = '0;
    for (int k = 0; k < 4; k++) begin
      if (cap_be[k]) rd_masked[8*k +: 8] = rd_word[8*k +: 8];
    end
  end

  // Next-state logic: wait states, one grant cycle, latency, data strobe.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    lcnt_d  = lcnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flash_mem_read) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            wcnt_d  = WCNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = GRANT;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == '0) state_d = GRANT;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      GRANT: begin
        if (READ_LATENCY > 1) begin
          state_d = LAT;
          lcnt_d  = LCNT_W'(READ_LATENCY - 2);
        end else begin
          state_d = VALID;
        end
      end
      LAT: begin
        if (lcnt_q == '0) state_d = VALID;
        else              lcnt_d  = lcnt_q - LCNT_W'(1);
      end
      VALID:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                     <= IDLE;
      wcnt_q                      <= '0;
      lcnt_q                      <= '0;
      cap_addr                    <= '0;
      cap_be                      <= '0;
      cap_burst                   <= 1'b0;
      bus.flash_mem_waitrequest   <= 1'b1;
      bus.flash_mem_readdatavalid <= 1'b0;
      bus.flash_mem_readdata      <= '0;
      addr_err                    <= 1'b0;
      reads_served                <= '0;
    end else begin
      state_q                     <= state_d;
      wcnt_q                      <= wcnt_d;
      lcnt_q                      <= lcnt_d;
      bus.flash_mem_waitrequest   <= (state_d != GRANT);
      bus.flash_mem_readdatavalid <= (state_d == VALID);
      if (capture) begin
        cap_addr  <= bus.flash_mem_address;
        cap_be    <= bus.flash_mem_byteenable;
        cap_burst <= bus.flash_mem_burstcount;
      end
      // Array read happens on the edge entering VALID; a same-edge load is not seen.
      if (state_d == VALID) begin
        if (legal) begin
          bus.flash_mem_readdata <= rd_masked;
        end else begin
          bus.flash_mem_readdata <= '0;
          addr_err               <= 1'b1;
        end
      end
      if (state_q == VALID) reads_served <= reads_served + 16'd1;
    end
  end

endmodule

// File: tb/tb_flash_responder.sv
// Directed bench for flash_responder: default timing instance plus a
// zero-wait, latency-1 instance sharing clock, reset and preload port.
`timescale 1ns/1ps
module tb_flash_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  logic        rd_req  [2];
  logic [22:0] rd_addr [2];
  logic [3:0]  rd_be   [2];
  logic        rd_bc   [2];
  logic [1:0]  wr, vld;
  logic [31:0] rdata   [2];
  logic        addr_err0, addr_err1;
  logic [15:0] served0, served1;

  int n_checks = 0;
  int n_fail   = 0;
  int vcount0  = 0;

  always #5 clk = ~clk;

  flash_responder_if #(.ADDR_W(23)) bus0 ();
  flash_responder_if #(.ADDR_W(23)) bus1 ();

  assign bus0.flash_mem_read       = rd_req[0];
  assign bus0.flash_mem_address    = rd_addr[0];
  assign bus0.flash_mem_byteenable = rd_be[0];
  assign bus0.flash_mem_burstcount = rd_bc[0];
  assign bus1.flash_mem_read       = rd_req[1];
  assign bus1.flash_mem_address    = rd_addr[1];
  assign bus1.flash_mem_byteenable = rd_be[1];
  assign bus1.flash_mem_burstcount = rd_bc[1];
  assign wr[0]    = bus0.flash_mem_waitrequest;
  assign wr[1]    = bus1.flash_mem_waitrequest;
  assign vld[0]   = bus0.flash_mem_readdatavalid;
  assign vld[1]   = bus1.flash_mem_readdatavalid;
  assign rdata[0] = bus0.flash_mem_readdata;
  assign rdata[1] = bus1.flash_mem_readdata;

  flash_responder #(.ADDR_W(23), .DEPTH(256), .WAIT_CYCLES(2), .READ_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .bus(bus0),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .addr_err(addr_err0), .reads_served(served0)
  );

  flash_responder #(.ADDR_W(23), .DEPTH(256), .WAIT_CYCLES(0), .READ_LATENCY(1)) dut_fast (
    .clk(clk), .rst(rst), .bus(bus1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .addr_err(addr_err1), .reads_served(served1)
  );

  // Count valid strobes of the default instance.
  always @(negedge clk) if (vld[0]) vcount0 = vcount0 + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int a);
    return {8'hA5, 8'(a), ~16'(a)};
  endfunction

  // One read holding read high until valid; cycle 0 is the first request cycle.
  task automatic read_word(input int s, input logic [22:0] a, input logic [3:0] be,
                           input logic bc, output logic [31:0] d, output int vcyc,
                           output logic [7:0] wv);
    @(posedge clk); #1;
    rd_req[s] = 1'b1; rd_addr[s] = a; rd_be[s] = be; rd_bc[s] = bc;
    vcyc = -1; wv = '1; d = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c < 8) wv[c] = wr[s];
      if (vld[s]) begin
        vcyc = c;
        d    = rdata[s];
        break;
      end
    end
    rd_req[s] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          vc;
    logic [7:0]  wv;
    int          snap;
    int          lat_strobes;

    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int s = 0; s < 2; s++) begin
      rd_req[s] = 1'b0; rd_addr[s] = '0; rd_be[s] = 4'hF; rd_bc[s] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_waitreq", 32'(wr[0]), 1);
    check("rst_valid", 32'(vld[0]), 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_addr_err", 32'(addr_err0), 0);
    check("rst_served", 32'(served0), 0);

    // Preload both arrays.
    @(posedge clk); #1;
    for (int a = 0; a < 256; a++) begin
      load_en = 1'b1; load_addr = 8'(a); load_data = pattern(a);
      @(posedge clk); #1;
    end
    load_en = 1'b0;

    // Default timing on address 7.
    read_word(0, 23'd7, 4'hF, 1'b1, d, vc, wv);
    check("t1_waitreq_pattern", 32'(wv), 32'h0000_00F7);
    check("t1_valid_cycle", vc, 5);
    check("t1_rdata", d, 32'hA507FFF8);

    // 128 sequential reads from a clean reset.
    do_reset();
    snap = vcount0;
    for (int a = 0; a < 128; a++) begin
      read_word(0, 23'(a), 4'hF, 1'b1, d, vc, wv);
      check($sformatf("seq_rdata_%0d", a), d, pattern(a));
    end
    repeat (10) @(posedge clk);
    #1;
    check("seq_strobes", vcount0 - snap, 128);
    check("seq_served", 32'(served0), 128);

    // Out-of-range address sets a sticky error.
    read_word(0, 23'd300, 4'hF, 1'b1, d, vc, wv);
    check("oor_rdata", d, 0);
    check("oor_addr_err", 32'(addr_err0), 1);
    read_word(0, 23'd9, 4'hF, 1'b1, d, vc, wv);
    check("oor_later_rdata", d, 32'hA509FFF6);
    check("oor_sticky", 32'(addr_err0), 1);
    do_reset();
    @(negedge clk);
    check("oor_cleared", 32'(addr_err0), 0);

    // Illegal burstcount.
    read_word(0, 23'd5, 4'hF, 1'b0, d, vc, wv);
    check("burst_rdata", d, 0);
    check("burst_addr_err", 32'(addr_err0), 1);

    // Byte-lane masking.
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 8'd10; load_data = 32'h11223344;
    @(posedge clk); #1;
    load_en = 1'b0;
    read_word(0, 23'd10, 4'b0101, 1'b1, d, vc, wv);
    check("be_rdata", d, 32'h00220044);

    // Reset during LAT aborts the read.
    @(posedge clk); #1;
    rd_req[0] = 1'b1; rd_addr[0] = 23'd7; rd_be[0] = 4'hF; rd_bc[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("lat_waitreq", 32'(wr[0]), 1);
    check("lat_valid", 32'(vld[0]), 0);
    rst = 1'b1; rd_req[0] = 1'b0;
    @(negedge clk);
    check("lat_rst_valid", 32'(vld[0]), 0);
    check("lat_rst_waitreq", 32'(wr[0]), 1);
    check("lat_rst_rdata", rdata[0], 0);
    rst = 1'b0;
    lat_strobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (vld[0]) lat_strobes++;
    end
    check("lat_no_strobe", lat_strobes, 0);
    read_word(0, 23'd7, 4'hF, 1'b1, d, vc, wv);
    check("lat_fresh_cycle", vc, 5);
    check("lat_fresh_rdata", d, 32'hA507FFF8);

    // Zero wait states, latency 1.
    read_word(1, 23'd20, 4'hF, 1'b1, d, vc, wv);
    check("fast_waitreq_pattern", 32'(wv), 32'h0000_00FD);
    check("fast_valid_cycle", vc, 2);
    check("fast_rdata", d, 32'hA514FFEB);

    // Load to the read address on the VALID-entry edge returns old data.
    @(posedge clk); #1;
    rd_req[1] = 1'b1; rd_addr[1] = 23'd21; rd_be[1] = 4'hF; rd_bc[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("same_edge_grant", 32'(wr[1]), 0);
    load_en = 1'b1; load_addr = 8'd21; load_data = 32'hDEADBEEF;
    @(negedge clk);
    load_en = 1'b0; rd_req[1] = 1'b0;
    check("same_edge_valid", 32'(vld[1]), 1);
    check("same_edge_old_data", rdata[1], 32'hA515FFEA);
    read_word(1, 23'd21, 4'hF, 1'b1, d, vc, wv);
    check("same_edge_new_data", d, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
